// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffers: bundle widths, field
// offsets inside each bundle, bubble (NOP) constants and a sizing helper.
package pipe_pkg;

   // Bundle widths for each stage boundary
   localparam int unsigned IDEX_W  = 91;
   localparam int unsigned EXMEM_W = 76;

   // Field offsets inside the ID/EX bundle
   localparam int unsigned IDEX_PC_LSB = 52;
   localparam int unsigned IDEX_PC_MSB = 83;

   // Field offsets inside the EX/MEM bundle
   localparam int unsigned EXMEM_FLAGS_LSB = 73;
   localparam int unsigned EXMEM_FLAGS_MSB = 75;

   typedef logic [IDEX_W-1:0]  idex_bundle_t;
   typedef logic [EXMEM_W-1:0] exmem_bundle_t;

   // Bubbles: every control bit deasserted
   localparam idex_bundle_t  IDEX_NOP  = '0;
   localparam exmem_bundle_t EXMEM_NOP = '0;

   // Bits needed to hold an occupancy count of 0..depth
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready/data stream between two pipeline stages. The producer side
// uses the master modport, the consumer side the slave modport.
interface pipe_stage_buffer_if #(
   parameter int unsigned WIDTH = 91
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buffer_exmem.sv
// EX/MEM boundary: buffer sized for the EX/MEM bundle with a two-entry queue.
module pipe_stage_buffer_exmem
   import pipe_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   pipe_stage_buffer_if.slave       in_if,
   pipe_stage_buffer_if.master      out_if,
   input  logic                     stall,
   input  logic                     flush,
   output logic [occ_width(2)-1:0]  occupancy,
   output logic [15:0]              squash_count
);

   pipe_stage_buffer #(
      .WIDTH     (EXMEM_W),
      .DEPTH     (2),
      .NOP_VALUE (EXMEM_NOP),
      .CNT_W     (16)
   ) u_buf (
      .clk          (clk),
      .rst          (rst),
      .in_if        (in_if),
      .out_if       (out_if),
      .stall        (stall),
      .flush        (flush),
      .occupancy    (occupancy),
      .squash_count (squash_count)
   );

endmodule

// File: rtl/pipe_stage_buffer_idex.sv
// ID/EX boundary: buffer sized for the ID/EX bundle with a two-entry queue.
module pipe_stage_buffer_idex
   import pipe_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   pipe_stage_buffer_if.slave       in_if,
   pipe_stage_buffer_if.master      out_if,
   input  logic                     stall,
   input  logic                     flush,
   output logic [occ_width(2)-1:0]  occupancy,
   output logic [15:0]              squash_count
);

   pipe_stage_buffer #(
      .WIDTH     (IDEX_W),
      .DEPTH     (2),
      .NOP_VALUE (IDEX_NOP),
      .CNT_W     (16)
   ) u_buf (
      .clk          (clk),
      .rst          (rst),
      .in_if        (in_if),
      .out_if       (out_if),
      .stall        (stall),
      .flush        (flush),
      .occupancy    (occupancy),
      .squash_count (squash_count)
   );

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO carrying an opaque
// WIDTH-bit bundle, with stall (freeze), flush (squash to a NOP bubble) and a
// saturating count of squashed entries for debug.
module pipe_stage_buffer
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 91,
   parameter int unsigned      DEPTH     = 2,
   parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
   parameter int unsigned      CNT_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   pipe_stage_buffer_if.slave            in_if,
   pipe_stage_buffer_if.master           out_if,
   input  logic                          stall,
   input  logic                          flush,
   output logic [occ_width(DEPTH)-1:0]   occupancy,
   output logic [CNT_W-1:0]              squash_count
);

   localparam int unsigned      OCC_W    = occ_width(DEPTH);
   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      SUM_W    = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
   localparam logic [SUM_W-1:0] CNT_MAX  = SUM_W'({CNT_W{1'b1}});

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             not_empty;
   logic             full;
   logic             push;
   logic             pop;
   logic [SUM_W-1:0] squash_sum;

   // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign not_empty = (occupancy != '0);
   assign full      = (occupancy == FULL_OCC);

   // A full buffer can still accept when the head leaves on the same edge
   assign in_if.ready = ~stall & ~flush & (~full | out_if.ready);
   assign push        = in_if.valid & in_if.ready;
   assign pop         = not_empty & out_if.ready & ~stall & ~flush;

   // Output comes from registers only; stale entries are masked by the bubble
   assign out_if.valid = not_empty;
   assign out_if.data  = not_empty ? mem[rd_ptr] : NOP_VALUE;

   // Entries discarded by a flush: everything held plus the bundle on offer
   assign squash_sum = SUM_W'(squash_count) + SUM_W'(occupancy) + SUM_W'(in_if.valid);

   // Write the incoming bundle into the tail slot
   // NOTE: storage has no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_if.data;
      end
   end

   // Pointer, occupancy and squash-counter update; flush wins over stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         occupancy    <= '0;
         squash_count <= '0;
      end else if (flush) begin
         rd_ptr       <= wr_ptr;
         occupancy    <= '0;
         squash_count <= (squash_sum > CNT_MAX) ? {CNT_W{1'b1}} : squash_sum[CNT_W-1:0];
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            occupancy <= occupancy + 1'b1;
         end else if (pop && !push) begin
            occupancy <= occupancy - 1'b1;
         end
      end
   end

endmodule
